// File: rtl/s3_pkg.sv
// S3 unpacker shared types and constants.
// Build option: S3_UNPACK_SIGNED_EN selects two's complement trits.
package s3_pkg;

  localparam int N      = 701;
  localparam int NBYTES = 140;
  localparam int IDXW   = 10;

  localparam logic [7:0] POW3 [0:4] =
    '{8'd1, 8'd3, 8'd9, 8'd27, 8'd81};

  localparam logic [7:0] NB_L = 8'(NBYTES);
  localparam logic [IDXW-1:0] LAST_IDX =
    IDXW'(N - 1);

  typedef logic [1:0] trit_t;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    EMIT,
    PAD
  } st_e;

  function automatic logic [7:0] pow3(
    input logic [2:0] k
  );
    logic [7:0] p;
    p = 8'd0;
    case (k)
      3'd0: p = POW3[0];
      3'd1: p = POW3[1];
      3'd2: p = POW3[2];
      3'd3: p = POW3[3];
      3'd4: p = POW3[4];
      default: p = 8'd0;
    endcase
    return p;
  endfunction

  // Digit 2 maps to -1 in the signed build.
  function automatic trit_t enc(
    input trit_t t
  );
`ifdef S3_UNPACK_SIGNED_EN
    return (t == 2'd2) ? 2'b11 : t;
`else
    return t;
`endif
  endfunction

endpackage

// File: rtl/s3_trit_cmp.sv
// One base-3 digit step by restoring compare.
// Ports: r, w=3^k, w2=2*3^k in; d, r_next out.
module s3_trit_cmp (
  input  logic [7:0] r,
  input  logic [7:0] w,
  input  logic [7:0] w2,
  output logic [1:0] d,
  output logic [7:0] r_next
);

  logic [7:0] s2;
  logic [7:0] s1;
  logic       c2;
  logic       c1;

  sub_2i8_o8 u_s2 (
    .x     (r),
    .y     (w2),
    .diff  (s2),
    .carry (c2)
  );

  sub_2i8_o8 u_s1 (
    .x     (r),
    .y     (w),
    .diff  (s1),
    .carry (c1)
  );

  always_comb begin
    d      = 2'd0;
    r_next = r;
    unique case (1'b1)
      c2: begin
        d      = 2'd2;
        r_next = s2;
      end
      (c1 & ~c2): begin
        d      = 2'd1;
        r_next = s1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sub_2i8_o8.sv
// 8-bit subtractor: diff = x - y, carry=1 when x >= y.
// Ports: x, y in; diff, carry out.
module sub_2i8_o8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] diff,
  output logic       carry
);

  assign {carry, diff} =
    {1'b0, x} + {1'b0, ~y} + 9'd1;

endmodule

// File: rtl/s3_byte_unpacker.sv
// Packed S3 byte stream to coefficient stream unpacker.
// Build option: S3_UNPACK_SIGNED_EN (signed trit encoding).
// Ports: clk, rst (sync, high); in_valid/in_ready/in_byte;
//   out_valid/out_ready/out_trit/out_idx/out_last; err, done.
module s3_byte_unpacker
  import s3_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_byte,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_trit,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic            err,
  output logic            done
);

  st_e             st;
  st_e             st_n;
  logic [7:0]      r;
  logic [2:0]      k;
  logic [2:0]      tix;
  trit_t           dig [0:4];
  logic [7:0]      bcnt;
  logic [IDXW-1:0] cidx;
  logic [7:0]      w;
  logic [7:0]      w2;
  logic [7:0]      r_nx;
  trit_t           d;
  logic            acc;
  logic            ill;
  logic            ohs;

  assign w  = pow3(k);
  assign w2 = {w[6:0], 1'b0};

  s3_trit_cmp u_cmp (
    .r      (r),
    .w      (w),
    .w2     (w2),
    .d      (d),
    .r_next (r_nx)
  );

  assign in_ready = (st == IDLE) & ~rst;
  assign acc      = in_valid & in_ready;
  assign ill      = in_byte > 8'd242;
  assign ohs      = out_valid & out_ready;

  always_comb begin
    st_n = st;
    unique case (st)
      IDLE: if (acc) st_n = DIV;
      DIV:  if (k == 3'd1) st_n = EMIT;
      EMIT:
        if (ohs && tix == 3'd4)
          st_n = (bcnt < NB_L) ? IDLE : PAD;
      PAD:  if (ohs) st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_trit  = 2'd0;
    out_idx   = '0;
    out_last  = 1'b0;
    unique case (1'b1)
      (st == EMIT): begin
        out_valid = 1'b1;
        out_trit  = enc(dig[tix]);
        out_idx   = cidx;
      end
      (st == PAD): begin
        out_valid = 1'b1;
        out_idx   = LAST_IDX;
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      r    <= 8'd0;
      k    <= 3'd0;
      tix  <= 3'd0;
      bcnt <= 8'd0;
      cidx <= '0;
      err  <= 1'b0;
      done <= 1'b0;
      dig  <= '{default: 2'd0};
    end else begin
      st   <= st_n;
      done <= 1'b0;
      // err lingers through the done cycle.
      if (done) err <= 1'b0;
      unique case (st)
        IDLE:
          if (acc) begin
            r    <= ill ? 8'd0 : in_byte;
            k    <= 3'd4;
            bcnt <= bcnt + 8'd1;
            if (ill) err <= 1'b1;
          end
        DIV: begin
          dig[k] <= d;
          r      <= r_nx;
          k      <= k - 3'd1;
          if (k == 3'd1) dig[0] <= r_nx[1:0];
        end
        EMIT:
          if (ohs) begin
            cidx <= cidx + 1'b1;
            tix  <= (tix == 3'd4) ? 3'd0
                                  : tix + 3'd1;
          end
        PAD:
          if (ohs) begin
            done <= 1'b1;
            bcnt <= 8'd0;
            cidx <= '0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s3_byte_unpacker.sv
// Scoreboard bench for s3_byte_unpacker.
// Expected coefficients come from a div/mod base-3 model.
module tb_s3_byte_unpacker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_trit;
  logic [9:0] out_idx;
  logic       out_last;
  logic       err;
  logic       done;

  typedef struct {
    int trit;
    int idx;
    int last;
    int err;
  } exp_t;

  exp_t q[$];

  int pass_n    = 0;
  int total_n   = 0;
  int done_cnt  = 0;
  int coef_n    = 0;
  int nbytes    = 0;
  int frame_err = 0;
  bit stall_arm = 0;
  bit bp_en     = 0;

  always #5 clk = ~clk;

  s3_byte_unpacker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_trit  (out_trit),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .err       (err),
    .done      (done)
  );

  task automatic chk(
    input string tag,
    input int    obs,
    input int    exp
  );
    total_n++;
    if (obs == exp) pass_n++;
    else
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
  endtask

  function automatic int enc(input int t);
`ifdef S3_UNPACK_SIGNED_EN
    return (t == 2) ? 3 : t;
`else
    return t;
`endif
  endfunction

  task automatic send_byte(input int b);
    int v;
    int n;
    exp_t e;
    if (b >= 243) frame_err = 1;
    v = (b >= 243) ? 0 : b;
    for (int i = 0; i < 5; i++) begin
      e.trit = enc(v % 3);
      e.idx  = coef_n;
      e.last = 0;
      e.err  = frame_err;
      q.push_back(e);
      v = v / 3;
      coef_n++;
    end
    nbytes++;
    if (nbytes == 140) begin
      e.trit = 0;
      e.idx  = 700;
      e.last = 1;
      e.err  = frame_err;
      q.push_back(e);
      nbytes    = 0;
      coef_n    = 0;
      frame_err = 0;
    end
    in_byte  = 8'(b);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready)
      chk("in_hs_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_byte  = 8'hff;
  endtask

  task automatic wait_drain(input int tgt);
    int n;
    n = 0;
    while ((q.size() != 0 || done_cnt < tgt)
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000)
      chk("drain_timeout", 0, 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  end

  initial begin
    int t0;
    int i0;
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_arm && out_valid
          && out_idx == 10'd12) begin
        stall_arm = 0;
        out_ready = 1'b0;
        t0 = int'(out_trit);
        i0 = int'(out_idx);
        repeat (3) begin
          @(negedge clk);
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_trit", int'(out_trit), t0);
          chk("hold_idx", int'(out_idx), i0);
        end
      end
      out_ready = bp_en
        ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out",
              int'(out_idx), -1);
        end else begin
          e = q.pop_front();
          chk("trit", int'(out_trit), e.trit);
          chk("idx", int'(out_idx), e.idx);
          chk("last", int'(out_last), e.last);
          chk("err", int'(err), e.err);
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_idx", int'(out_idx), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 1);

    stall_arm = 1;
    send_byte(0);
    send_byte(242);
    send_byte(100);
    send_byte(81);
    send_byte(250);
    for (int i = 5; i < 140; i++)
      send_byte($urandom_range(0, 242));
    wait_drain(1);
    chk("f1_done_cnt", done_cnt, 1);
    chk("f1_stall_used", int'(stall_arm), 0);
    repeat (2) @(negedge clk);
    chk("f1_err_clear", int'(err), 0);

    for (int i = 0; i < 70; i++)
      send_byte($urandom_range(0, 242));
    wait_drain(1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_ready", int'(in_ready), 0);
    rst       = 1'b0;
    nbytes    = 0;
    coef_n    = 0;
    frame_err = 0;
    @(negedge clk);

    bp_en = 1;
    for (int i = 0; i < 140; i++)
      send_byte($urandom_range(0, 242));
    wait_drain(2);
    repeat (4) @(negedge clk);
    chk("f3_done_cnt", done_cnt, 2);
    chk("q_empty", q.size(), 0);
    chk("f3_err", int'(err), 0);

    $display("%0d/%0d checks passed",
             pass_n, total_n);
    $finish;
  end

endmodule
